// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared LSU definitions: ls_info bit positions, FSM state encoding, access
// size codes and small decode helpers used by the LSU top and its aligner.
package ysyx_22040237_lsu_pkg;

  // ls_info bus layout: {dw, word, db, byte, usign, store, load}
  localparam int LS_INFO_W = 7;
  localparam int LS_LOAD   = 0;
  localparam int LS_STORE  = 1;
  localparam int LS_USIGN  = 2;
  localparam int LS_BYTE   = 3;
  localparam int LS_DB     = 4;
  localparam int LS_WORD   = 5;
  localparam int LS_DW     = 6;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_WB   = 2'd3
  } lsu_state_e;

  // log2 of the access size in bytes
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  // Size bits are {dw, word, db, byte}; a non-one-hot pattern is rejected
  // separately, so the fallback code here never reaches memory.
  function automatic lsu_size_e size_code(input logic [3:0] sz);
    lsu_size_e code;
    case (sz)
      4'b0010: code = SIZE_H;
      4'b0100: code = SIZE_W;
      4'b1000: code = SIZE_D;
      default: code = SIZE_B;
    endcase
    return code;
  endfunction

  function automatic logic size_is_onehot(input logic [3:0] sz);
    return (sz != 4'd0) && ((sz & (sz - 4'd1)) == 4'd0);
  endfunction

  function automatic logic misaligned(input lsu_size_e sz, input logic [2:0] off);
    logic bad;
    case (sz)
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = |off[1:0];
      SIZE_D:  bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Byte-lane aligner for the LSU (purely combinational).
// Ports:
//   store_i      : access is a store (write mask forced to 0 otherwise)
//   usign_i      : zero-extend load data instead of sign-extending
//   size_i       : access size code
//   off_i        : byte offset inside the 8-byte beat
//   rs2_i        : store data, LSB-justified
//   rdata_i      : full 8-byte read beat
//   wmask_o      : byte-lane write mask
//   wdata_o      : store data shifted to its lanes
//   load_data_o  : extracted, extended load result
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            store_i,
  input  logic            usign_i,
  input  lsu_size_e       size_i,
  input  logic [2:0]      off_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [7:0]      wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [5:0]      bit_off;
  logic [7:0]      base_mask;
  logic [XLEN-1:0] shifted;
  logic            sext;

  assign bit_off = {off_i, 3'b000};

  always_comb begin
    case (size_i)
      SIZE_H:  base_mask = 8'h03;
      SIZE_W:  base_mask = 8'h0F;
      SIZE_D:  base_mask = 8'hFF;
      default: base_mask = 8'h01;
    endcase
  end

  // Only aligned accesses reach memory, so the shifted mask never overflows.
  assign wmask_o = store_i ? (base_mask << off_i) : 8'h00;
  assign wdata_o = rs2_i << bit_off;
  assign shifted = rdata_i >> bit_off;
  assign sext    = ~usign_i;

  always_comb begin
    case (size_i)
      SIZE_B:  load_data_o = {{(XLEN-8){sext & shifted[7]}},   shifted[7:0]};
      SIZE_H:  load_data_o = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      SIZE_W:  load_data_o = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: captures one instruction, issues at most one memory
// request, waits for its response and hands the result to writeback.
// Non-memory instructions pass addr_i straight to writeback.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   ls_valid_i / ls_ready_o  : upstream handshake (ready only in IDLE)
//   ls_info_bus_i            : {dw, word, db, byte, usign, store, load}
//   addr_i, rs2_store_i      : effective address / ALU result, store data
//   rd_wr_en_i, rd_idx_i     : destination register control
//   mem_req_*                : request channel (8-byte aligned address)
//   mem_rsp_*                : response channel (full 8-byte beat)
//   wb_*                     : writeback channel
//   ls_err_o                 : one-cycle pulse following capture of an illegal op
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ls_valid_i,
  output logic                 ls_ready_o,
  input  logic [LS_INFO_W-1:0] ls_info_bus_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      rs2_store_i,
  input  logic                 rd_wr_en_i,
  input  logic [4:0]           rd_idx_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_req_we_o,
  output logic [AW-1:0]        mem_req_addr_o,
  output logic [XLEN-1:0]      mem_req_wdata_o,
  output logic [7:0]           mem_req_wmask_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [XLEN-1:0]      mem_rsp_rdata_i,
  output logic                 mem_rsp_ready_o,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic                 wb_rd_wr_en_o,
  output logic [4:0]           wb_rd_idx_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic                 ls_err_o
);

  lsu_state_e state_q, state_d;

  logic [LS_INFO_W-1:0] info_q;
  logic [XLEN-1:0]      addr_q;
  logic [XLEN-1:0]      rs2_q;
  logic [4:0]           rd_idx_q;
  logic                 wb_rd_wr_en_q;
  logic [XLEN-1:0]      wb_data_q;
  logic                 ls_err_q;

  // Decode of the incoming instruction, used only at capture time.
  logic      load_in, store_in, ls_in, err_in, capture;
  lsu_size_e size_in;

  assign load_in  = ls_info_bus_i[LS_LOAD];
  assign store_in = ls_info_bus_i[LS_STORE];
  assign ls_in    = load_in | store_in;
  assign size_in  = size_code(ls_info_bus_i[LS_DW:LS_BYTE]);
  assign err_in   = (load_in & store_in)
                  | (ls_in & (~size_is_onehot(ls_info_bus_i[LS_DW:LS_BYTE])
                              | misaligned(size_in, addr_i[2:0])));
  assign capture  = ls_valid_i & (state_q == LSU_IDLE);

  always_comb begin
    state_d         = state_q;
    ls_ready_o      = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    wb_valid_o      = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        ls_ready_o = 1'b1;
        if (ls_valid_i) state_d = (err_in || !ls_in) ? LSU_WB : LSU_REQ;
      end
      LSU_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = LSU_RSP;
      end
      LSU_RSP: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i) state_d = LSU_WB;
      end
      LSU_WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LSU_IDLE;
    else      state_q <= state_d;
  end

  logic [XLEN-1:0] load_data;

  ysyx_22040237_lsu_align #(.XLEN(XLEN)) u_align (
    .store_i     (info_q[LS_STORE]),
    .usign_i     (info_q[LS_USIGN]),
    .size_i      (size_code(info_q[LS_DW:LS_BYTE])),
    .off_i       (addr_q[2:0]),
    .rs2_i       (rs2_q),
    .rdata_i     (mem_rsp_rdata_i),
    .wmask_o     (mem_req_wmask_o),
    .wdata_o     (mem_req_wdata_o),
    .load_data_o (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      info_q        <= '0;
      addr_q        <= '0;
      rs2_q         <= '0;
      rd_idx_q      <= '0;
      wb_rd_wr_en_q <= 1'b0;
      wb_data_q     <= '0;
      ls_err_q      <= 1'b0;
    end else begin
      ls_err_q <= capture & err_in;
      if (capture) begin
        info_q        <= ls_info_bus_i;
        addr_q        <= addr_i;
        rs2_q         <= rs2_store_i;
        rd_idx_q      <= rd_idx_i;
        // Stores and rejected ops never write the register file.
        wb_rd_wr_en_q <= rd_wr_en_i & ~store_in & ~err_in;
        wb_data_q     <= ls_in ? '0 : addr_i;
      end else if (state_q == LSU_RSP && mem_rsp_valid_i) begin
        wb_data_q <= info_q[LS_LOAD] ? load_data : '0;
      end
    end
  end

  logic [AW-1:0] addr_aw;
  assign addr_aw        = AW'(addr_q);
  assign mem_req_addr_o = addr_aw & ~AW'(3'b111);
  assign mem_req_we_o   = info_q[LS_STORE];
  assign wb_rd_wr_en_o  = wb_rd_wr_en_q;
  assign wb_rd_idx_o    = rd_idx_q;
  assign wb_data_o      = wb_data_q;
  assign ls_err_o       = ls_err_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
module tb_ysyx_22040237_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid_i;
  logic        ls_ready_o;
  logic [6:0]  ls_info_bus_i;
  logic [63:0] addr_i, rs2_store_i;
  logic        rd_wr_en_i;
  logic [4:0]  rd_idx_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [63:0] mem_req_addr_o, mem_req_wdata_o;
  logic [7:0]  mem_req_wmask_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rsp_rdata_i;
  logic        mem_rsp_ready_o;
  logic        wb_valid_o, wb_ready_i, wb_rd_wr_en_o;
  logic [4:0]  wb_rd_idx_o;
  logic [63:0] wb_data_o;
  logic        ls_err_o;

  always #5 clk = ~clk;

  ysyx_22040237_lsu #(.XLEN(64), .AW(64)) dut (
    .clk(clk), .rst(rst),
    .ls_valid_i(ls_valid_i), .ls_ready_o(ls_ready_o),
    .ls_info_bus_i(ls_info_bus_i), .addr_i(addr_i), .rs2_store_i(rs2_store_i),
    .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wmask_o(mem_req_wmask_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .mem_rsp_ready_o(mem_rsp_ready_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_wr_en_o(wb_rd_wr_en_o), .wb_rd_idx_o(wb_rd_idx_o), .wb_data_o(wb_data_o),
    .ls_err_o(ls_err_o)
  );

  typedef struct {
    logic [6:0]  info;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic        wen;
    logic [4:0]  idx;
    logic [63:0] rdata;
    int          req_stall;
    int          rsp_delay;
    int          wb_stall;
    logic        noise;
  } op_t;

  typedef struct {
    logic        err;
    logic        req;
    logic        we;
    logic [63:0] maddr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        wb_wen;
    logic [63:0] wb_data;
    logic        chk_data;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t ex;
  } vec_t;

  typedef struct {
    logic        pre_ready, comb_req, err, err_late;
    logic        req_seen, req_unstable, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        wb_seen, wb_unstable, wb_wen;
    logic [4:0]  wb_idx;
    logic [63:0] wb_data;
    logic        ready_busy, ready_after;
  } res_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: derived from the access rules byte by byte.
  function automatic exp_t model(input op_t op);
    exp_t e;
    logic ld, st, us;
    int   nb, ones, off;
    logic [63:0] v;
    e = '{err:0, req:0, we:0, maddr:0, wdata:0, wmask:0, wb_wen:0, wb_data:0, chk_data:0};
    ld = op.info[0]; st = op.info[1]; us = op.info[2];
    ones = $countones(op.info[6:3]);
    nb = op.info[3] ? 1 : op.info[4] ? 2 : op.info[5] ? 4 : 8;
    off = int'(op.addr[2:0]);
    if (!ld && !st) begin
      e.wb_wen = op.wen; e.wb_data = op.addr; e.chk_data = 1;
    end else if ((ld && st) || ones != 1 || (off % nb) != 0) begin
      e.err = 1;
    end else begin
      e.req = 1; e.we = st;
      e.maddr = op.addr & ~64'h7;
      for (int b = 0; b < 8; b++) begin
        if (b >= off) e.wdata[8*b +: 8] = op.rs2[8*(b-off) +: 8];
        if (st && b >= off && b < off + nb) e.wmask[b] = 1'b1;
      end
      e.chk_data = 1;
      if (ld) begin
        v = 64'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = op.rdata[8*(off+i) +: 8];
        if (!us && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        e.wb_wen = op.wen; e.wb_data = v;
      end
    end
    return e;
  endfunction

  // Drives one instruction through the DUT, acting as memory and writeback.
  task automatic do_op(input op_t op, output res_t r);
    int req_wait, rsp_wait, wb_wait;
    bit done;
    r = '{default:0};
    req_wait = 0; rsp_wait = 0; wb_wait = 0; done = 0;
    ls_valid_i = 1; ls_info_bus_i = op.info; addr_i = op.addr;
    rs2_store_i = op.rs2; rd_wr_en_i = op.wen; rd_idx_i = op.idx;
    #1;
    r.pre_ready = ls_ready_o;
    r.comb_req  = mem_req_valid_o;
    @(posedge clk); #1;
    ls_valid_i = 0;
    ls_info_bus_i = 7'($urandom); addr_i = {$urandom, $urandom};
    rs2_store_i = {$urandom, $urandom}; rd_wr_en_i = 1'($urandom); rd_idx_i = 5'($urandom);
    r.err = ls_err_o;
    for (int c = 0; c < 60 && !done; c++) begin
      mem_req_ready_i = 0; wb_ready_i = 0;
      mem_rsp_valid_i = op.noise; mem_rsp_rdata_i = {$urandom, $urandom};
      if (c > 0 && ls_err_o) r.err_late = 1;
      if (ls_ready_o) r.ready_busy = 1;
      if (mem_req_valid_o) begin
        if (!r.req_seen) begin
          r.req_addr = mem_req_addr_o; r.req_we = mem_req_we_o;
          r.req_wdata = mem_req_wdata_o; r.req_wmask = mem_req_wmask_o;
        end else if (r.req_addr !== mem_req_addr_o || r.req_we !== mem_req_we_o ||
                     r.req_wdata !== mem_req_wdata_o || r.req_wmask !== mem_req_wmask_o)
          r.req_unstable = 1;
        r.req_seen = 1;
        if (req_wait >= op.req_stall) mem_req_ready_i = 1; else req_wait++;
      end
      if (mem_rsp_ready_o) begin
        if (rsp_wait >= op.rsp_delay) begin
          mem_rsp_valid_i = 1; mem_rsp_rdata_i = op.rdata;
        end else begin
          mem_rsp_valid_i = 0; rsp_wait++;
        end
      end
      if (wb_valid_o) begin
        if (!r.wb_seen) begin
          r.wb_wen = wb_rd_wr_en_o; r.wb_idx = wb_rd_idx_o; r.wb_data = wb_data_o;
        end else if (r.wb_wen !== wb_rd_wr_en_o || r.wb_idx !== wb_rd_idx_o ||
                     r.wb_data !== wb_data_o)
          r.wb_unstable = 1;
        r.wb_seen = 1;
        if (wb_wait >= op.wb_stall) begin wb_ready_i = 1; done = 1; end
        else wb_wait++;
      end
      @(posedge clk); #1;
    end
    mem_req_ready_i = 0; mem_rsp_valid_i = 0; wb_ready_i = 0;
    r.ready_after = ls_ready_o;
  endtask

  task automatic compare(input string tag, input op_t op, input exp_t ex, input res_t r);
    chk({tag, ":ready_before"}, 64'(r.pre_ready), 64'd1);
    chk({tag, ":no_comb_req"}, 64'(r.comb_req), 64'd0);
    chk({tag, ":err_pulse"}, 64'(r.err), 64'(ex.err));
    chk({tag, ":err_one_cycle"}, 64'(r.err_late), 64'd0);
    chk({tag, ":req_seen"}, 64'(r.req_seen), 64'(ex.req));
    if (ex.req) begin
      chk({tag, ":req_addr"}, r.req_addr, ex.maddr);
      chk({tag, ":req_we"}, 64'(r.req_we), 64'(ex.we));
      chk({tag, ":req_wmask"}, 64'(r.req_wmask), 64'(ex.wmask));
      if (ex.we) chk({tag, ":req_wdata"}, r.req_wdata, ex.wdata);
      chk({tag, ":req_stable"}, 64'(r.req_unstable), 64'd0);
    end
    chk({tag, ":wb_seen"}, 64'(r.wb_seen), 64'd1);
    chk({tag, ":wb_wen"}, 64'(r.wb_wen), 64'(ex.wb_wen));
    chk({tag, ":wb_idx"}, 64'(r.wb_idx), 64'(op.idx));
    if (ex.chk_data) chk({tag, ":wb_data"}, r.wb_data, ex.wb_data);
    chk({tag, ":wb_stable"}, 64'(r.wb_unstable), 64'd0);
    chk({tag, ":ready_while_busy"}, 64'(r.ready_busy), 64'd0);
    chk({tag, ":ready_after"}, 64'(r.ready_after), 64'd1);
    $display("TXN %s info=%h addr=%h req=%0d err=%0d wb_wen=%0d wb_data=%h",
             tag, op.info, op.addr, r.req_seen, r.err, r.wb_wen, r.wb_data);
  endtask

  vec_t vt[12];
  op_t  op;
  exp_t ex;
  res_t rs;

  initial begin
    ls_valid_i = 0; ls_info_bus_i = 0; addr_i = 0; rs2_store_i = 0;
    rd_wr_en_i = 0; rd_idx_i = 0; mem_req_ready_i = 0; mem_rsp_valid_i = 0;
    mem_rsp_rdata_i = 0; wb_ready_i = 0; rst = 0;

    vt[0].op  = '{info:7'h09, addr:64'h80000003, rs2:64'h0, wen:1, idx:5'd10, rdata:64'h0000_0000_8000_0000, req_stall:0, rsp_delay:0, wb_stall:0, noise:0};
    vt[0].ex  = '{err:0, req:1, we:0, maddr:64'h80000000, wdata:0, wmask:8'h00, wb_wen:1, wb_data:64'hFFFF_FFFF_FFFF_FF80, chk_data:1};
    vt[1].op  = '{info:7'h12, addr:64'h80000006, rs2:64'h1234, wen:1, idx:5'd3, rdata:64'h0, req_stall:1, rsp_delay:0, wb_stall:0, noise:0};
    vt[1].ex  = '{err:0, req:1, we:1, maddr:64'h80000000, wdata:64'h1234_0000_0000_0000, wmask:8'hC0, wb_wen:0, wb_data:64'h0, chk_data:1};
    vt[2].op  = '{info:7'h25, addr:64'h80000004, rs2:64'h0, wen:1, idx:5'd12, rdata:64'hDEAD_BEEF_1357_9BDF, req_stall:3, rsp_delay:2, wb_stall:0, noise:1};
    vt[2].ex  = '{err:0, req:1, we:0, maddr:64'h80000000, wdata:0, wmask:8'h00, wb_wen:1, wb_data:64'h0000_0000_DEAD_BEEF, chk_data:1};
    vt[3].op  = '{info:7'h41, addr:64'h80000004, rs2:64'h0, wen:1, idx:5'd8, rdata:64'h0, req_stall:0, rsp_delay:0, wb_stall:0, noise:0};
    vt[3].ex  = '{err:1, req:0, we:0, maddr:0, wdata:0, wmask:0, wb_wen:0, wb_data:0, chk_data:0};
    vt[4].op  = '{info:7'h00, addr:64'h42, rs2:64'h0, wen:1, idx:5'd5, rdata:64'h0, req_stall:0, rsp_delay:0, wb_stall:2, noise:1};
    vt[4].ex  = '{err:0, req:0, we:0, maddr:0, wdata:0, wmask:0, wb_wen:1, wb_data:64'h42, chk_data:1};
    vt[5].op  = '{info:7'h0B, addr:64'h80000001, rs2:64'h0, wen:1, idx:5'd1, rdata:64'h0, req_stall:0, rsp_delay:0, wb_stall:0, noise:0};
    vt[5].ex  = '{err:1, req:0, we:0, maddr:0, wdata:0, wmask:0, wb_wen:0, wb_data:0, chk_data:0};
    vt[6].op  = '{info:7'h19, addr:64'h80000000, rs2:64'h0, wen:1, idx:5'd2, rdata:64'h0, req_stall:0, rsp_delay:0, wb_stall:0, noise:0};
    vt[6].ex  = '{err:1, req:0, we:0, maddr:0, wdata:0, wmask:0, wb_wen:0, wb_data:0, chk_data:0};
    vt[7].op  = '{info:7'h42, addr:64'h80000010, rs2:64'h0102030405060708, wen:1, idx:5'd4, rdata:64'h0, req_stall:0, rsp_delay:1, wb_stall:1, noise:0};
    vt[7].ex  = '{err:0, req:1, we:1, maddr:64'h80000010, wdata:64'h0102030405060708, wmask:8'hFF, wb_wen:0, wb_data:64'h0, chk_data:1};
    vt[8].op  = '{info:7'h0D, addr:64'h80000007, rs2:64'h0, wen:1, idx:5'd6, rdata:64'h8000_0000_0000_0000, req_stall:0, rsp_delay:0, wb_stall:0, noise:1};
    vt[8].ex  = '{err:0, req:1, we:0, maddr:64'h80000000, wdata:0, wmask:8'h00, wb_wen:1, wb_data:64'h80, chk_data:1};
    vt[9].op  = '{info:7'h11, addr:64'h80000002, rs2:64'h0, wen:1, idx:5'd7, rdata:64'h0000_0000_8001_0000, req_stall:0, rsp_delay:0, wb_stall:0, noise:0};
    vt[9].ex  = '{err:0, req:1, we:0, maddr:64'h80000000, wdata:0, wmask:8'h00, wb_wen:1, wb_data:64'hFFFF_FFFF_FFFF_8001, chk_data:1};
    vt[10].op = '{info:7'h0A, addr:64'h1005, rs2:64'hAB, wen:1, idx:5'd9, rdata:64'h0, req_stall:0, rsp_delay:0, wb_stall:0, noise:0};
    vt[10].ex = '{err:0, req:1, we:1, maddr:64'h1000, wdata:64'h0000_AB00_0000_0000, wmask:8'h20, wb_wen:0, wb_data:64'h0, chk_data:1};
    vt[11].op = '{info:7'h22, addr:64'h2002, rs2:64'h55, wen:1, idx:5'd11, rdata:64'h0, req_stall:0, rsp_delay:0, wb_stall:0, noise:0};
    vt[11].ex = '{err:1, req:0, we:0, maddr:0, wdata:0, wmask:0, wb_wen:0, wb_data:0, chk_data:0};

    // Reset state, both during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst:ready_in_reset", 64'(ls_ready_o), 64'd1);
    chk("rst:req_valid_in_reset", 64'(mem_req_valid_o), 64'd0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("rst:ready", 64'(ls_ready_o), 64'd1);
    chk("rst:req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("rst:rsp_ready", 64'(mem_rsp_ready_o), 64'd0);
    chk("rst:wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst:err", 64'(ls_err_o), 64'd0);
    chk("rst:wb_data", wb_data_o, 64'd0);
    chk("rst:wmask", 64'(mem_req_wmask_o), 64'd0);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      do_op(vt[i].op, rs);
      compare($sformatf("vec%0d", i), vt[i].op, vt[i].ex, rs);
    end

    // Reset asserted while waiting for a response.
    ls_valid_i = 1; ls_info_bus_i = 7'h41; addr_i = 64'h80000008;
    rd_wr_en_i = 1; rd_idx_i = 5'd7;
    @(posedge clk); #1;
    ls_valid_i = 0;
    chk("midrst:req_valid", 64'(mem_req_valid_o), 64'd1);
    mem_req_ready_i = 1;
    @(posedge clk); #1;
    mem_req_ready_i = 0;
    chk("midrst:in_rsp", 64'(mem_rsp_ready_o), 64'd1);
    rst = 0; #1;
    chk("midrst:ready", 64'(ls_ready_o), 64'd1);
    chk("midrst:req_valid0", 64'(mem_req_valid_o), 64'd0);
    chk("midrst:rsp_ready0", 64'(mem_rsp_ready_o), 64'd0);
    chk("midrst:wb_valid0", 64'(wb_valid_o), 64'd0);
    chk("midrst:err0", 64'(ls_err_o), 64'd0);
    $display("TXN midrst reset applied in RSP");
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    op = '{info:7'h41, addr:64'h80000008, rs2:64'h0, wen:1, idx:5'd7, rdata:64'hCAFE_F00D_1234_5678, req_stall:1, rsp_delay:1, wb_stall:0, noise:0};
    ex = '{err:0, req:1, we:0, maddr:64'h80000008, wdata:0, wmask:8'h00, wb_wen:1, wb_data:64'hCAFE_F00D_1234_5678, chk_data:1};
    do_op(op, rs);
    compare("after_rst", op, ex, rs);

    // Randomized operations against the reference model.
    for (int n = 0; n < 200; n++) begin
      int k, sz;
      k = $urandom_range(0, 9);
      op.addr = {$urandom, $urandom};
      op.rs2 = {$urandom, $urandom};
      op.rdata = {$urandom, $urandom};
      op.wen = 1'($urandom);
      op.idx = 5'($urandom);
      op.req_stall = $urandom_range(0, 3);
      op.rsp_delay = $urandom_range(0, 3);
      op.wb_stall = $urandom_range(0, 2);
      op.noise = 1'($urandom);
      if (k < 2) begin
        op.info = 7'h00;
      end else if (k < 8) begin
        sz = $urandom_range(0, 3);
        op.info = 7'(1 << (3 + sz));
        op.info[2] = 1'($urandom);
        op.info[1:0] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        if ($urandom_range(0, 3) != 0) op.addr = op.addr & ~((64'd1 << sz) - 64'd1);
      end else begin
        op.info = 7'($urandom);
        if (op.info[1:0] == 2'b00) op.info[6:3] = 4'd0;
      end
      ex = model(op);
      do_op(op, rs);
      compare($sformatf("rnd%0d", n), op, ex, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
